// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life board stepper.
//   state_e          : stepper FSM states
//   NW..SE           : bit positions of the eight neighbours in the neighbourhood vector
//   wrap_dec/wrap_inc: modulo-n coordinate step used for toroidal wrap
package gol_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EVAL   = 2'd2,
    COMMIT = 2'd3
  } state_e;

  localparam int unsigned NW = 0;
  localparam int unsigned N  = 1;
  localparam int unsigned NE = 2;
  localparam int unsigned W  = 3;
  localparam int unsigned E  = 4;
  localparam int unsigned SW = 5;
  localparam int unsigned S  = 6;
  localparam int unsigned SE = 7;

  // v-1 mod n
  function automatic int unsigned wrap_dec(input int unsigned v, input int unsigned n);
    return (v == 0) ? n - 1 : v - 1;
  endfunction

  // v+1 mod n
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/gameoflife.sv
// Combinational Conway cell evaluator.
//   i0..i7 : the eight neighbour cells
//   mid    : the cell itself
//   alive  : cell value in the next generation
module gameoflife (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic i4,
  input  logic i5,
  input  logic i6,
  input  logic i7,
  input  logic mid,
  output logic alive
);

  logic [3:0] cnt_c;

  assign cnt_c = 4'(i0) + 4'(i1) + 4'(i2) + 4'(i3)
               + 4'(i4) + 4'(i5) + 4'(i6) + 4'(i7);

  // Birth on exactly 3, survival on 2 or 3
  assign alive = (cnt_c == 4'd3) | (mid & (cnt_c == 4'd2));

endmodule

// File: rtl/gol_grid_stepper.sv
// Toroidal Game of Life board stepper: serial load, one-cell-per-cycle
// evaluation through a single gameoflife cell, atomic commit, row readout.
//   load_start/load_valid/load_bit/load_ready : serial row-major board load
//   step/busy/done                            : generation command and status
//   gen_count                                 : generations since last load
//   rd_row/rd_data                            : committed board row readout
module gol_grid_stepper
  import gol_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 8,
  parameter int unsigned GEN_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_start,
  input  logic                      load_valid,
  input  logic                      load_bit,
  output logic                      load_ready,
  input  logic                      step,
  output logic                      busy,
  output logic                      done,
  output logic [GEN_W-1:0]          gen_count,
  input  logic [$clog2(HEIGHT)-1:0] rd_row,
  output logic [WIDTH-1:0]          rd_data
);

  localparam int unsigned XW = $clog2(WIDTH);
  localparam int unsigned YW = $clog2(HEIGHT);

  state_e                        state_q;
  logic [HEIGHT-1:0][WIDTH-1:0]  cur_q;
  logic [HEIGHT-1:0][WIDTH-1:0]  nxt_q;
  logic [XW-1:0]                 x_q;
  logic [YW-1:0]                 y_q;
  logic                          load_ready_q;
  logic                          busy_q;
  logic                          done_q;
  logic [GEN_W-1:0]              gen_q;

  logic [XW-1:0] xm_c, xp_c, x_adv_c;
  logic [YW-1:0] ym_c, yp_c, y_adv_c;
  logic          last_cell_c;
  logic [7:0]    nbr_c;
  logic          alive_c;

  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign gen_count  = gen_q;
  assign rd_data    = cur_q[rd_row];

  // Shared load/scan index: wrapped neighbour coordinates and row-major advance
  always_comb begin
    xm_c        = XW'(wrap_dec(32'(x_q), WIDTH));
    xp_c        = XW'(wrap_inc(32'(x_q), WIDTH));
    ym_c        = YW'(wrap_dec(32'(y_q), HEIGHT));
    yp_c        = YW'(wrap_inc(32'(y_q), HEIGHT));
    last_cell_c = (x_q == XW'(WIDTH - 1)) && (y_q == YW'(HEIGHT - 1));
    x_adv_c     = xp_c;
    y_adv_c     = (x_q == XW'(WIDTH - 1)) ? yp_c : y_q;
  end

  // Neighbourhood mux; reads only the committed board
  always_comb begin
    nbr_c          = '0;
    nbr_c[3'(NW)]  = cur_q[ym_c][xm_c];
    nbr_c[3'(N)]   = cur_q[ym_c][x_q];
    nbr_c[3'(NE)]  = cur_q[ym_c][xp_c];
    nbr_c[3'(W)]   = cur_q[y_q][xm_c];
    nbr_c[3'(E)]   = cur_q[y_q][xp_c];
    nbr_c[3'(SW)]  = cur_q[yp_c][xm_c];
    nbr_c[3'(S)]   = cur_q[yp_c][x_q];
    nbr_c[3'(SE)]  = cur_q[yp_c][xp_c];
  end

  gameoflife u_cell (
    .i0    (nbr_c[3'(NW)]),
    .i1    (nbr_c[3'(N)]),
    .i2    (nbr_c[3'(NE)]),
    .i3    (nbr_c[3'(W)]),
    .i4    (nbr_c[3'(E)]),
    .i5    (nbr_c[3'(SW)]),
    .i6    (nbr_c[3'(S)]),
    .i7    (nbr_c[3'(SE)]),
    .mid   (cur_q[y_q][x_q]),
    .alive (alive_c)
  );

  // Control FSM with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      nxt_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      load_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      gen_q        <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Load takes precedence over step
          if (load_start) begin
            state_q      <= LOAD;
            x_q          <= '0;
            y_q          <= '0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end else if (step) begin
            state_q <= EVAL;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          if (load_valid) begin
            cur_q[y_q][x_q] <= load_bit;
            if (last_cell_c) begin
              state_q      <= IDLE;
              load_ready_q <= 1'b0;
              busy_q       <= 1'b0;
              gen_q        <= '0;
            end else begin
              x_q <= x_adv_c;
              y_q <= y_adv_c;
            end
          end
        end
        EVAL: begin
          nxt_q[y_q][x_q] <= alive_c;
          if (last_cell_c) begin
            state_q <= COMMIT;
          end else begin
            x_q <= x_adv_c;
            y_q <= y_adv_c;
          end
        end
        COMMIT: begin
          cur_q   <= nxt_q;
          gen_q   <= gen_q + GEN_W'(1);
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_grid_stepper.sv
// Scoreboard bench for gol_grid_stepper: the stimulus process pushes expected
// boards (from a neighbour-counting reference model) and the monitor checks
// them on every done pulse or snapshot request.
module tb_gol_grid_stepper;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int N  = W * H;
  localparam int GW = 16;

  typedef logic [H-1:0][W-1:0] board_t;
  typedef struct {
    board_t b;
    int     gen;
    int     due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_bit = 1'b0;
  logic          load_ready;
  logic          step = 1'b0;
  logic          busy;
  logic          done;
  logic [GW-1:0] gen_count;
  logic [2:0]    rd_row = 3'd0;
  logic [W-1:0]  rd_data;

  gol_grid_stepper #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_bit   (load_bit),
    .load_ready (load_ready),
    .step       (step),
    .busy       (busy),
    .done       (done),
    .gen_count  (gen_count),
    .rd_row     (rd_row),
    .rd_data    (rd_data)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     total = 0;
  int     bad = 0;
  exp_t   done_q[$];
  exp_t   snap_q[$];
  board_t mcur = '0;
  int     mgen = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: count the eight toroidal neighbours of every cell
  function automatic board_t model_step(input board_t b);
    board_t nb;
    nb = '0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        int n;
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (dy != 0 || dx != 0)
              n += int'(b[(y + dy + H) % H][(x + dx + W) % W]);
        nb[y][x] = (n == 3) || (b[y][x] && n == 2);
      end
    end
    return nb;
  endfunction

  // Monitor-only row readout of the whole board
  task automatic mon_board(input string tag, input board_t e);
    for (int r = 0; r < H; r++) begin
      rd_row = 3'(r);
      #1;
      chk($sformatf("%s row%0d", tag, r), rd_data, e[r]);
    end
  endtask

  // Monitor: done pulses pop the done queue, otherwise serve snapshot requests
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (done) begin
        if (done_q.size() == 0) begin
          chk("unexpected done", done, 0);
        end else begin
          e = done_q.pop_front();
          chk("done latency", cyc, e.due);
          chk("gen_count at done", gen_count, e.gen);
          chk("busy at done", busy, 0);
          mon_board("done", e.b);
        end
        @(negedge clk);
        chk("done one cycle", done, 0);
      end else if (snap_q.size() > 0) begin
        e = snap_q.pop_front();
        chk("snap gen_count", gen_count, e.gen);
        chk("snap busy", busy, 0);
        mon_board("snap", e.b);
      end
    end
  end

  task automatic wait_sb();
    int t;
    t = 0;
    while ((done_q.size() > 0 || snap_q.size() > 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard drain", done_q.size() + snap_q.size(), 0);
    done_q.delete();
    snap_q.delete();
  endtask

  task automatic snap_exp(input board_t b);
    snap_q.push_back('{b, mgen, -1});
    wait_sb();
  endtask

  task automatic load_board(input board_t b, input bit with_step);
    @(negedge clk);
    load_start = 1'b1;
    step = with_step;
    @(posedge clk);
    #1;
    load_start = 1'b0;
    step = 1'b0;
    chk("load_ready on start", load_ready, 1);
    chk("busy on load", busy, 1);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      while ($urandom_range(3) == 0) begin
        load_valid = 1'b0;
        step = 1'($urandom_range(1));
        load_start = 1'($urandom_range(1));
        @(negedge clk);
      end
      step = 1'b0;
      load_start = 1'b0;
      load_valid = 1'b1;
      load_bit = b[i / W][i % W];
    end
    @(negedge clk);
    load_valid = 1'b0;
    chk("load_ready after load", load_ready, 0);
    chk("busy after load", busy, 0);
    mcur = b;
    mgen = 0;
    snap_exp(mcur);
  endtask

  task automatic do_step(input bit noise);
    board_t nb;
    nb = model_step(mcur);
    mgen = (mgen + 1) % (1 << GW);
    @(negedge clk);
    step = 1'b1;
    done_q.push_back('{nb, mgen, cyc + N + 2});
    @(posedge clk);
    #1;
    step = 1'b0;
    chk("busy in eval", busy, 1);
    chk("load_ready in eval", load_ready, 0);
    if (noise) begin
      repeat (6) begin
        @(negedge clk);
        step = 1'($urandom_range(1));
        load_start = 1'($urandom_range(1));
        load_valid = 1'($urandom_range(1));
        load_bit = 1'($urandom_range(1));
      end
      @(negedge clk);
      step = 1'b0;
      load_start = 1'b0;
      load_valid = 1'b0;
    end
    mcur = nb;
    wait_sb();
  endtask

  function automatic board_t rand_board();
    board_t b;
    for (int y = 0; y < H; y++) b[y] = W'($urandom);
    return b;
  endfunction

  initial begin
    board_t b, g, gt;
    #3;
    chk("reset busy", busy, 0);
    chk("reset load_ready", load_ready, 0);
    chk("reset done", done, 0);
    chk("reset gen_count", gen_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    snap_exp('0);

    // Blinker
    b = '0;
    b[3] = 8'h1C;
    load_board(b, 1'b0);
    do_step(1'b0);
    g = '0;
    g[2] = 8'h08; g[3] = 8'h08; g[4] = 8'h08;
    snap_exp(g);
    do_step(1'b0);
    snap_exp(b);

    // Block still life
    b = '0;
    b[1] = 8'h06; b[2] = 8'h06;
    load_board(b, 1'b0);
    repeat (3) do_step(1'b0);
    snap_exp(b);

    // Glider crossing both edges; after 4 gens it shifts by (+1,+1)
    g = '0; gt = '0;
    g[6][7] = 1'b1; g[7][0] = 1'b1; g[0][6] = 1'b1; g[0][7] = 1'b1; g[0][0] = 1'b1;
    gt[7][0] = 1'b1; gt[0][1] = 1'b1; gt[1][7] = 1'b1; gt[1][0] = 1'b1; gt[1][1] = 1'b1;
    load_board(g, 1'b0);
    repeat (4) do_step(1'b0);
    snap_exp(gt);

    // Overcrowding
    load_board('1, 1'b0);
    do_step(1'b0);
    snap_exp('0);

    // Load wins over simultaneous step; stray commands while busy are ignored
    load_board(rand_board(), 1'b1);
    do_step(1'b1);
    do_step(1'b1);

    // Random boards
    repeat (4) begin
      load_board(rand_board(), 1'b0);
      repeat (3) do_step(1'b1);
    end

    // Reset at scan index 20 abandons the generation
    load_board(rand_board(), 1'b0);
    @(negedge clk);
    step = 1'b1;
    @(posedge clk);
    #1;
    step = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset load_ready", load_ready, 0);
    chk("midreset done", done, 0);
    chk("midreset gen_count", gen_count, 0);
    mcur = '0;
    mgen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    snap_exp('0);
    repeat (3) @(negedge clk);
    load_board(rand_board(), 1'b0);
    do_step(1'b0);
    do_step(1'b1);

    wait_sb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/gol_grid_stepper.md
Name: gol_grid_stepper

Overview:
- Sequential driver for the combinational `gameoflife` cell evaluator: the producing end of its 9-input neighbourhood interface.
- Holds a toroidal WIDTH x HEIGHT board in registers and sweeps it one cell per cycle.
- For each cell it presents i0..i7 and mid to one `gameoflife` instance and captures `alive` into a next-generation buffer, then commits the whole board atomically.
- Provides serial board load, a step command and row readout.

Parameters:
- WIDTH, 8, board columns (>=3)
- HEIGHT, 8, board rows (>=3)
- GEN_W, 16, generation counter width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset; asynchronous assert, active-low
- load_start  input  1  begin serial board load (honoured only in IDLE)
- load_valid  input  1  load_bit valid
- load_bit  input  1  cell value, row-major order: index = y*WIDTH + x
- load_ready  output  1  high only in LOAD
- step  input  1  compute one generation (honoured only in IDLE)
- busy  output  1  high in LOAD, EVAL and COMMIT
- done  output  1  one-cycle pulse after a generation commits
- gen_count  output  GEN_W  generations committed since the last load
- rd_row  input  clog2(HEIGHT)  readout row select
- rd_data  output  WIDTH  committed board row rd_row; bit x = column x; combinational from the current board

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - Current and next boards are all 0; load and scan indices are 0.
  - load_ready=0, busy=0, done=0, gen_count=0.
  - Reset mid-LOAD, mid-EVAL or mid-COMMIT abandons the operation and leaves no partial board.
- States: IDLE, LOAD, EVAL, COMMIT.
- IDLE:
  - load_start=1 -> LOAD, with the load index cleared.
  - Otherwise step=1 -> EVAL, with the scan index cleared.
  - If both are high, load wins and step is dropped.
- LOAD:
  - Each cycle with load_valid && load_ready writes load_bit to the current board at the load index, then increments the index.
  - On the WIDTH*HEIGHT-th accepted bit: go to IDLE, set gen_count to 0.
  - load_valid=0 stalls with no timeout.
  - load_start and step are ignored.
- EVAL:
  - One cell per cycle, scan index s = 0 .. WIDTH*HEIGHT-1, with x = s mod WIDTH and y = s div WIDTH.
  - Neighbour mapping, all coordinates modulo WIDTH/HEIGHT (toroidal wrap): i0=(x-1,y-1), i1=(x,y-1), i2=(x+1,y-1), i3=(x-1,y), i4=(x+1,y), i5=(x-1,y+1), i6=(x,y+1), i7=(x+1,y+1), mid=(x,y).
  - All reads come from the current board only, so the current board is unchanged during EVAL.
  - `alive` for cell s is written into next[y][x] on the same edge.
  - After s=WIDTH*HEIGHT-1 -> COMMIT.
  - EVAL lasts exactly WIDTH*HEIGHT cycles.
- COMMIT (1 cycle):
  - current <= next.
  - gen_count <= gen_count+1, wrapping at 2^GEN_W.
  - Go to IDLE; done=1 in the following cycle only.
- Step latency:
  - step sampled at edge k -> done high during the cycle after edge k+WIDTH*HEIGHT+1.
  - busy is high from edge k until edge k+WIDTH*HEIGHT+1.
  - A new step may be sampled in the same cycle that done is high.
- step, load_start, load_valid while busy (outside their own state): ignored, no side effects.
- rd_data:
  - Always reflects the committed board.
  - During EVAL it shows the previous generation; it never shows a partial generation.

Decomposition:
- Shared package `gol_pkg`:
  - state enum {IDLE, LOAD, EVAL, COMMIT}
  - neighbour index constants NW=0, N=1, NE=2, W=3, E=4, SW=5, S=6, SE=7
  - helper functions for wrap decrement/increment
- Sub-module: instantiate the existing `gameoflife` cell as the evaluator; no new sub-module.
- Neighbourhood muxing stays in gol_grid_stepper.

Test Plan:
- Blinker on 8x8: load row 3 = 8'h1C, all other rows 0; step -> after done, rows 2,3,4 = 8'h08, others 0, gen_count=1; second step -> row 3 = 8'h1C again, gen_count=2.
- Block still life: rows 1,2 = 8'h06; step 3 times -> rows unchanged, gen_count=3; each done arrives exactly 66 cycles after step is sampled.
- Wrap: glider with cells at x=7 and x=0 crossing the edge; 4 steps -> same shape translated by (+1,+1) mod 8; cross-check all 64 cells against a reference model.
- Overcrowding: all 64 cells = 1; step -> all rows 8'h00 (every cell has popcount 8).
- Command precedence: load_start and step high together in IDLE -> LOAD entered, load_ready=1, no EVAL occurs; step pulsed while busy -> ignored, gen_count increments only once.
- Reset mid-EVAL: assert rst_n=0 at scan index 20 -> immediately busy=0, load_ready=0, gen_count=0, all rd_data=0, state IDLE; after release a new load and step behave normally.
